// File: rtl/vga_write_arbiter.sv
// Burst-level round-robin arbiter for the single vga_adapter pixel-write port.
// One drawing engine owns the port for its whole burst; a watchdog revokes
// ownership from an engine that holds the grant without writing.
module vga_write_arbiter #(
   parameter int N_REQ    = 3,
   parameter int nX       = 10,
   parameter int nY       = 9,
   parameter int COLOR_W  = 9,
   parameter int MAX_IDLE = 1024,
   parameter int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                       CLOCK_50,
   input  logic                       Resetn,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*nX-1:0]        req_x,
   input  logic [N_REQ*nY-1:0]        req_y,
   input  logic [N_REQ*COLOR_W-1:0]   req_color,
   input  logic [N_REQ-1:0]           req_write,
   input  logic                       clr_timeout,
   output logic [N_REQ-1:0]           gnt,
   output logic [IW-1:0]              owner,
   output logic                       busy,
   output logic                       timeout_flag,
   output logic [nX-1:0]              VGA_x,
   output logic [nY-1:0]              VGA_y,
   output logic [COLOR_W-1:0]         VGA_color,
   output logic                       VGA_write
);

   localparam int WD_W = (MAX_IDLE > 2) ? $clog2(MAX_IDLE) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_IDLE - 1);
   localparam logic [IW-1:0]   LAST_REQ = IW'(N_REQ - 1);

   typedef enum logic {S_IDLE, S_OWN} state_t;

   state_t              state_q, state_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic [IW-1:0]       owner_q, owner_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [N_REQ-1:0]    mask_q, mask_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic                timeout_q, timeout_d;
   logic [nX-1:0]       vx_q, vx_d;
   logic [nY-1:0]       vy_q, vy_d;
   logic [COLOR_W-1:0]  vc_q, vc_d;
   logic                vw_q, vw_d;

   logic [N_REQ-1:0]    elig;
   logic                pick_found;
   logic [IW-1:0]       pick_idx;
   logic [IW-1:0]       ptr_next;
   logic                own_req;
   logic                own_wr;
   logic [nX-1:0]       own_x;
   logic [nY-1:0]       own_y;
   logic [COLOR_W-1:0]  own_c;

   // Round-robin pick: first eligible requester scanning upward from ptr.
   always_comb begin
      int unsigned idx;
      idx        = 0;
      elig       = req & ~mask_q;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = (32'(ptr_q) + i) % N_REQ;
         if (!pick_found && elig[idx]) begin
            pick_found = 1'b1;
            pick_idx   = IW'(idx);
         end
      end
   end

   // Current owner's request lines and the pointer value following it.
   always_comb begin
      own_req  = req[owner_q];
      own_wr   = req_write[owner_q];
      own_x    = req_x[owner_q*nX +: nX];
      own_y    = req_y[owner_q*nY +: nY];
      own_c    = req_color[owner_q*COLOR_W +: COLOR_W];
      ptr_next = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;
   end

   // Next-state logic: grant, release, watchdog revocation and pixel forwarding.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      wd_d      = wd_q;
      // A masked requester is unmasked as soon as it is seen with req low.
      mask_d    = mask_q & req;
      timeout_d = timeout_q & ~clr_timeout;
      vx_d      = vx_q;
      vy_d      = vy_q;
      vc_d      = vc_q;
      vw_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               state_d = S_OWN;
               gnt_d   = N_REQ'(1) << pick_idx;
               owner_d = pick_idx;
               wd_d    = '0;
            end
         end
         S_OWN: begin
            // Owner's pixel is forwarded even in its release/revoke cycle.
            vw_d = own_wr;
            if (own_wr) begin
               vx_d = own_x;
               vy_d = own_y;
               vc_d = own_c;
            end
            if (!own_req) begin
               // Release takes priority over a simultaneous watchdog expiry.
               state_d = S_IDLE;
               gnt_d   = '0;
               ptr_d   = ptr_next;
            end else if (wd_q == WD_LAST) begin
               state_d         = S_IDLE;
               gnt_d           = '0;
               ptr_d           = ptr_next;
               timeout_d       = 1'b1;
               mask_d[owner_q] = 1'b1;
            end else if (own_wr) begin
               wd_d = '0;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         mask_q    <= '0;
         wd_q      <= '0;
         timeout_q <= 1'b0;
         vx_q      <= '0;
         vy_q      <= '0;
         vc_q      <= '0;
         vw_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         mask_q    <= mask_d;
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
         vx_q      <= vx_d;
         vy_q      <= vy_d;
         vc_q      <= vc_d;
         vw_q      <= vw_d;
      end
   end

   assign gnt          = gnt_q;
   assign owner        = owner_q;
   assign busy         = |gnt_q;
   assign timeout_flag = timeout_q;
   assign VGA_x        = vx_q;
   assign VGA_y        = vy_q;
   assign VGA_color    = vc_q;
   assign VGA_write    = vw_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Scoreboard bench for vga_write_arbiter: every pixel the bench expects to be
// forwarded is queued with the edge it must appear after; a negedge monitor
// pops and compares, and flags any write the queue does not account for.
module tb_vga_write_arbiter;

   localparam int N  = 3;
   localparam int XW = 10;
   localparam int YW = 9;
   localparam int CW = 9;

   logic                CLOCK_50 = 1'b0;
   logic                Resetn;
   logic [N-1:0]        req;
   logic [N*XW-1:0]     req_x;
   logic [N*YW-1:0]     req_y;
   logic [N*CW-1:0]     req_color;
   logic [N-1:0]        req_write;
   logic                clr_timeout;
   logic [N-1:0]        gnt;
   logic [1:0]          owner;
   logic                busy;
   logic                timeout_flag;
   logic [XW-1:0]       VGA_x;
   logic [YW-1:0]       VGA_y;
   logic [CW-1:0]       VGA_color;
   logic                VGA_write;

   vga_write_arbiter #(
      .N_REQ(N), .nX(XW), .nY(YW), .COLOR_W(CW), .MAX_IDLE(8)
   ) dut (
      .CLOCK_50(CLOCK_50), .Resetn(Resetn), .req(req), .req_x(req_x),
      .req_y(req_y), .req_color(req_color), .req_write(req_write),
      .clr_timeout(clr_timeout), .gnt(gnt), .owner(owner), .busy(busy),
      .timeout_flag(timeout_flag), .VGA_x(VGA_x), .VGA_y(VGA_y),
      .VGA_color(VGA_color), .VGA_write(VGA_write)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      int unsigned   due;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [CW-1:0] c;
   } px_t;

   px_t          sb[$];
   int unsigned  edge_n = 0;
   int           n_vec  = 0;
   int           n_err  = 0;
   logic [N-1:0] exp_gnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_px(input int k, input int x, input int y, input int c);
      req_x[k*XW +: XW]     = XW'(x);
      req_y[k*YW +: YW]     = YW'(y);
      req_color[k*CW +: CW] = CW'(c);
   endtask

   // Queue the pixels that the expected owner presents, then advance one edge.
   task automatic step();
      for (int k = 0; k < N; k++) begin
         if (Resetn && exp_gnt[k] && req_write[k])
            sb.push_back('{due: edge_n + 1, x: req_x[k*XW +: XW],
                           y: req_y[k*YW +: YW], c: req_color[k*CW +: CW]});
      end
      @(posedge CLOCK_50);
      #1;
   endtask

   always @(posedge CLOCK_50) edge_n <= edge_n + 1;

   // Output monitor: VGA_write must be high exactly when a queued pixel is due.
   always @(negedge CLOCK_50) begin
      logic exp_w;
      px_t  p;
      exp_w = (sb.size() > 0) && (sb[0].due == edge_n);
      chk("vga_write", 32'(VGA_write), 32'(exp_w));
      if (exp_w) begin
         p = sb.pop_front();
         chk("vga_x", 32'(VGA_x), 32'(p.x));
         chk("vga_y", 32'(VGA_y), 32'(p.y));
         chk("vga_color", 32'(VGA_color), 32'(p.c));
      end
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: got no finish expected finish by %0t", $time);
      $fatal(1);
   end

   initial begin
      int nxt;
      Resetn = 1'b0; req = '0; req_write = '0; req_x = '0; req_y = '0;
      req_color = '0; clr_timeout = 1'b0; exp_gnt = '0;
      step(); step();
      Resetn = 1'b1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_flag", 32'(timeout_flag), 0);
      chk("rst_vx", 32'(VGA_x), 0);
      chk("rst_vy", 32'(VGA_y), 0);
      chk("rst_vc", 32'(VGA_color), 0);
      chk("rst_vw", 32'(VGA_write), 0);
      step(); step();

      // Single requester streaming a pixel every cycle.
      req = 3'b010; set_px(1, 100, 50, 9'h1FF); req_write = 3'b010;
      step(); exp_gnt = 3'b010;
      chk("s1_gnt", 32'(gnt), 32'h2);
      chk("s1_owner", 32'(owner), 1);
      chk("s1_busy", 32'(busy), 1);
      repeat (5) step();
      req = '0;
      step(); exp_gnt = '0;
      chk("s1_rel_gnt", 32'(gnt), 0);
      chk("s1_rel_busy", 32'(busy), 0);
      chk("s1_owner_hold", 32'(owner), 1);
      req_write = '0;
      step();
      chk("s1_hold_x", 32'(VGA_x), 100);
      step();

      // Round robin from reset, with non-owners writing junk pixels.
      Resetn = 1'b0; step(); Resetn = 1'b1; exp_gnt = '0;
      req = 3'b111;
      step(); exp_gnt = 3'b001;
      chk("rr_gnt_first", 32'(gnt), 32'h1);
      for (int o = 0; o < N; o++) begin
         for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < N; k++) begin
               if (k == o) set_px(k, 200 + o*10 + i, 20 + i, o + 1);
               else        set_px(k, 900 + k, 1, 0);
            end
            req_write = 3'b111;
            step();
         end
         req_write = '0; req[o] = 1'b0;
         step(); exp_gnt = '0;
         chk("rr_gap", 32'(gnt), 0);
         step();
         nxt = (o + 1) % N;
         exp_gnt = 3'b001 << nxt;
         chk("rr_gnt_next", 32'(gnt), 32'(exp_gnt));
         chk("rr_owner", 32'(owner), 32'(nxt));
         req[o] = 1'b1;
      end
      req = '0;
      step(); exp_gnt = '0;
      step();

      // Intrusion: requester 2 strobes writes while 0 owns the port.
      req = 3'b001;
      step(); exp_gnt = 3'b001;
      chk("intr_gnt", 32'(gnt), 32'h1);
      for (int i = 0; i < 6; i++) begin
         set_px(0, 300 + i, 60, 9'h0AA);
         set_px(2, 7, 7, 9'h007);
         req_write = {i[0], 1'b0, 1'b1};
         step();
         chk("intr_x", 32'(VGA_x == 10'd7), 0);
      end
      req = '0; req_write = '0;
      step(); exp_gnt = '0;
      step();

      // Watchdog: owner 1 stalls while requester 0 waits.
      req = 3'b011;
      step(); exp_gnt = 3'b010;
      chk("wd_gnt", 32'(gnt), 32'h2);
      for (int i = 0; i < 7; i++) begin
         step();
         chk("wd_hold", 32'(gnt), 32'h2);
      end
      step(); exp_gnt = '0;
      chk("wd_revoke", 32'(gnt), 0);
      chk("wd_flag", 32'(timeout_flag), 1);
      step(); exp_gnt = 3'b001;
      chk("wd_next", 32'(gnt), 32'h1);
      set_px(0, 400, 70, 9'h155); req_write = 3'b001;
      step(); step();
      req_write = '0; req = 3'b010;
      step(); exp_gnt = '0;
      chk("wd_rel0", 32'(gnt), 0);
      step();
      chk("wd_masked_a", 32'(gnt), 0);
      step();
      chk("wd_masked_b", 32'(gnt), 0);
      req = '0;
      step();
      chk("wd_unmask", 32'(gnt), 0);
      req = 3'b010;
      step(); exp_gnt = 3'b010;
      chk("wd_regrant", 32'(gnt), 32'h2);
      chk("wd_flag_sticky", 32'(timeout_flag), 1);
      clr_timeout = 1'b1;
      step();
      clr_timeout = 1'b0;
      chk("wd_clr", 32'(timeout_flag), 0);
      req = '0;
      step(); exp_gnt = '0;
      step();

      // Release on the exact cycle the watchdog would expire.
      req = 3'b100;
      step(); exp_gnt = 3'b100;
      chk("rx_gnt", 32'(gnt), 32'h4);
      repeat (7) step();
      req = '0;
      step(); exp_gnt = '0;
      chk("rx_rel", 32'(gnt), 0);
      chk("rx_flag", 32'(timeout_flag), 0);
      req = 3'b100;
      step(); exp_gnt = 3'b100;
      chk("rx_nomask", 32'(gnt), 32'h4);
      req = '0;
      step(); exp_gnt = '0;
      step();

      // Reset in the middle of a burst, with the pointer moved off zero.
      req = 3'b001;
      step(); exp_gnt = 3'b001;
      set_px(0, 500, 80, 9'h011); req_write = 3'b001;
      step();
      req = '0; req_write = '0;
      step(); exp_gnt = '0;
      req = 3'b010;
      step(); exp_gnt = 3'b010;
      chk("mr_gnt1", 32'(gnt), 32'h2);
      set_px(1, 600, 90, 9'h0F0); req_write = 3'b010;
      step(); step();
      Resetn = 1'b0; req = 3'b111; set_px(1, 611, 91, 9'h0F1);
      step(); exp_gnt = '0;
      Resetn = 1'b1; req_write = '0;
      chk("mr_gnt", 32'(gnt), 0);
      chk("mr_busy", 32'(busy), 0);
      chk("mr_owner", 32'(owner), 0);
      chk("mr_vw", 32'(VGA_write), 0);
      chk("mr_vx", 32'(VGA_x), 0);
      chk("mr_vy", 32'(VGA_y), 0);
      chk("mr_vc", 32'(VGA_color), 0);
      step(); exp_gnt = 3'b001;
      chk("mr_restart", 32'(gnt), 32'h1);
      req = '0;
      step(); exp_gnt = '0;
      step(); step();
      @(negedge CLOCK_50);
      #1;
      chk("sb_empty", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
